// File: rtl/palm_locator.sv
// Raster-order palm locator: finds the first row holding a long object run, counts how many
// consecutive rows keep one, and publishes the geometry once per frame, one cycle after the last pixel.
module palm_locator #(
  parameter int unsigned IMG_WIDTH    = 128,
  parameter int unsigned IMG_HEIGHT   = 96,
  parameter int unsigned MIN_PALM_RUN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       object_image,
  input  logic       pixel_valid,
  output logic [7:0] start_of_palm_r,
  output logic [7:0] start_of_palm_c,
  output logic [7:0] end_of_palm_r,
  output logic [7:0] end_of_palm_c,
  output logic [7:0] palm_width,
  output logic [7:0] palm_height,
  output logic       palm_found,
  output logic       params_valid
);

  localparam logic [7:0] LastCol = 8'(IMG_WIDTH - 1);
  localparam logic [7:0] LastRow = 8'(IMG_HEIGHT - 1);
  localparam logic [8:0] MinRun  = 9'(MIN_PALM_RUN);

  typedef enum logic [1:0] {StSearch, StMeasure, StDone} state_e;

  state_e     state_q, state_d, st_eval;
  logic [7:0] r_q, c_q;
  logic [8:0] run_len_q, best_len_q;
  logic [7:0] run_start_q, best_start_q, best_end_q;
  logic [7:0] w_r_q, w_sc_q, w_ec_q, w_h_q;
  logic [7:0] w_r_d, w_sc_d, w_ec_d, w_h_d;
  logic [7:0] w_r_e, w_sc_e, w_ec_e, w_h_e;

  logic [8:0] cur_len, row_len;
  logic [7:0] cur_start, row_start, row_end;
  logic       take, row_done, frame_end, is_palm, found_e;

  logic [7:0] out_sr_q, out_sc_q, out_ec_q, out_w_q, out_h_q;
  logic       out_found_q, out_pv_q;

  // Row-best values as they stand including the pixel accepted this cycle.
  always_comb begin
    cur_len   = run_len_q + 9'd1;
    cur_start = (run_len_q == 9'd0) ? c_q : run_start_q;
    take      = object_image && (cur_len > best_len_q);
    row_len   = take ? cur_len   : best_len_q;
    row_start = take ? cur_start : best_start_q;
    row_end   = take ? c_q       : best_end_q;
    row_done  = pixel_valid && (c_q == LastCol);
    frame_end = row_done && (r_q == LastRow);
    is_palm   = row_len >= MinRun;
  end

  always_comb begin
    st_eval = state_q;
    w_r_e   = w_r_q;
    w_sc_e  = w_sc_q;
    w_ec_e  = w_ec_q;
    w_h_e   = w_h_q;
    if (row_done) begin
      unique case (state_q)
        StSearch: begin
          if (is_palm) begin
            st_eval = StMeasure;
            w_r_e   = r_q;
            w_sc_e  = row_start;
            w_ec_e  = row_end;
            w_h_e   = 8'd1;
          end
        end
        StMeasure: begin
          if (is_palm) begin
            if (w_h_q != 8'hff) w_h_e = w_h_q + 8'd1;
          end else begin
            st_eval = StDone;
          end
        end
        default: st_eval = StDone;
      endcase
    end
    found_e = (st_eval != StSearch);

    state_d = st_eval;
    w_r_d   = w_r_e;
    w_sc_d  = w_sc_e;
    w_ec_d  = w_ec_e;
    w_h_d   = w_h_e;
    if (frame_end) begin
      state_d = StSearch;
      w_r_d   = 8'd0;
      w_sc_d  = 8'd0;
      w_ec_d  = 8'd0;
      w_h_d   = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSearch;
      w_r_q   <= 8'd0;
      w_sc_q  <= 8'd0;
      w_ec_q  <= 8'd0;
      w_h_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      w_r_q   <= w_r_d;
      w_sc_q  <= w_sc_d;
      w_ec_q  <= w_ec_d;
      w_h_q   <= w_h_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q          <= 8'd0;
      c_q          <= 8'd0;
      run_len_q    <= 9'd0;
      run_start_q  <= 8'd0;
      best_len_q   <= 9'd0;
      best_start_q <= 8'd0;
      best_end_q   <= 8'd0;
    end else if (pixel_valid) begin
      if (row_done) begin
        c_q          <= 8'd0;
        r_q          <= (r_q == LastRow) ? 8'd0 : r_q + 8'd1;
        run_len_q    <= 9'd0;
        run_start_q  <= 8'd0;
        best_len_q   <= 9'd0;
        best_start_q <= 8'd0;
        best_end_q   <= 8'd0;
      end else begin
        c_q <= c_q + 8'd1;
        if (object_image) begin
          run_len_q    <= cur_len;
          run_start_q  <= cur_start;
          best_len_q   <= row_len;
          best_start_q <= row_start;
          best_end_q   <= row_end;
        end else begin
          run_len_q <= 9'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sr_q    <= 8'd0;
      out_sc_q    <= 8'd0;
      out_ec_q    <= 8'd0;
      out_w_q     <= 8'd0;
      out_h_q     <= 8'd0;
      out_found_q <= 1'b0;
      out_pv_q    <= 1'b0;
    end else begin
      out_pv_q <= frame_end;
      if (frame_end) begin
        out_found_q <= found_e;
        out_sr_q    <= found_e ? w_r_e : 8'd0;
        out_sc_q    <= found_e ? w_sc_e : 8'd0;
        out_ec_q    <= found_e ? w_ec_e : 8'd0;
        out_w_q     <= found_e ? (w_ec_e - w_sc_e) : 8'd0;
        out_h_q     <= found_e ? w_h_e : 8'd0;
      end
    end
  end

  assign start_of_palm_r = out_sr_q;
  assign start_of_palm_c = out_sc_q;
  assign end_of_palm_r   = out_sr_q;
  assign end_of_palm_c   = out_ec_q;
  assign palm_width      = out_w_q;
  assign palm_height     = out_h_q;
  assign palm_found      = out_found_q;
  assign params_valid    = out_pv_q;

endmodule

// File: tb/tb_palm_locator.sv
// Directed bench for palm_locator at default geometry: rectangle, empty, threshold/tie,
// edge run with input gaps, and mid-frame reset.
module tb_palm_locator;

  localparam int W = 128;
  localparam int H = 96;

  logic       clk, rst, object_image, pixel_valid;
  logic [7:0] start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c;
  logic [7:0] palm_width, palm_height;
  logic       palm_found, params_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int pulse_base;

  palm_locator dut (
    .clk             (clk),
    .rst             (rst),
    .object_image    (object_image),
    .pixel_valid     (pixel_valid),
    .start_of_palm_r (start_of_palm_r),
    .start_of_palm_c (start_of_palm_c),
    .end_of_palm_r   (end_of_palm_r),
    .end_of_palm_c   (end_of_palm_c),
    .palm_width      (palm_width),
    .palm_height     (palm_height),
    .palm_found      (palm_found),
    .params_valid    (params_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (params_valid) pulses <= pulses + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input int pv, input int sr, input int sc,
                           input int ec, input int w, input int h, input int f);
    check({tag, "_pv"},  int'(params_valid),    pv);
    check({tag, "_sr"},  int'(start_of_palm_r), sr);
    check({tag, "_sc"},  int'(start_of_palm_c), sc);
    check({tag, "_er"},  int'(end_of_palm_r),   sr);
    check({tag, "_ec"},  int'(end_of_palm_c),   ec);
    check({tag, "_w"},   int'(palm_width),      w);
    check({tag, "_h"},   int'(palm_height),     h);
    check({tag, "_f"},   int'(palm_found),      f);
  endtask

  // 0 rectangle, 1 empty, 2 threshold/tie, 3 edge run
  function automatic logic pix(input int kind, input int r, input int c);
    case (kind)
      0: return (r >= 10 && r <= 48 && c >= 78 && c <= 110);
      2: return (r == 5 && c <= 14) ||
                (r == 6 && ((c >= 20 && c <= 35) || (c >= 50 && c <= 65)));
      3: return (r <= 2 && c >= 100);
      default: return 1'b0;
    endcase
  endfunction

  // Returns #1 after the edge accepting the last pixel; pixel_valid is left high.
  task automatic send_frame(input int kind, input bit gaps, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < W; c++) begin
        object_image = pix(kind, r, c);
        pixel_valid  = 1'b1;
        @(posedge clk);
        #1;
        if (gaps && (r <= 3 || r == H - 1) && !(r == H - 1 && c == W - 1)) begin
          pixel_valid  = 1'b0;
          object_image = 1'b1;
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    pixel_valid  = 1'b0;
    object_image = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_out("reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    send_frame(0, 1'b0, H);
    check_out("rect", 1, 10, 78, 110, 32, 39, 1);
    send_frame(1, 1'b0, H);
    check_out("empty", 1, 0, 0, 0, 0, 0, 0);
    send_frame(2, 1'b0, H);
    check_out("thresh", 1, 6, 20, 35, 15, 1, 1);
    send_frame(3, 1'b1, H);
    check_out("edge", 1, 0, 100, 127, 27, 3, 1);
    pixel_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pv_one_cycle", int'(params_valid), 0);

    pulse_base = pulses;
    send_frame(0, 1'b0, 30);
    pixel_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_out("midrst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(0, 1'b0, H);
    check_out("rect2", 1, 10, 78, 110, 32, 39, 1);
    pixel_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pulses_after_rst", pulses - pulse_base, 1);
    check("pulses_total", pulses, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/palm_locator.md
# palm_locator

Streaming front-end that scans a binary object image in raster order, one pixel per accepted cycle, and locates the palm. It finds the first row containing a sufficiently long horizontal object run, measures how many consecutive rows keep such a run, and publishes the palm geometry once per frame. It sits directly upstream of the finger identification stage and drives its palm_width, palm_height, start_of_palm_r/c and end_of_palm_r/c inputs.

## Interface
- IMG_WIDTH, 128, pixels per row (2..256)
- IMG_HEIGHT, 96, rows per frame (2..256)
- MIN_PALM_RUN, 16, minimum run length in pixels, inclusive, for a row to count as palm
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, asynchronous, active-high
- object_image  input  1  current pixel (1 = object)
- pixel_valid  input  1  object_image is sampled only when high
- start_of_palm_r  output  8  row of first palm row
- start_of_palm_c  output  8  first column of that row's palm run
- end_of_palm_r  output  8  equals start_of_palm_r
- end_of_palm_c  output  8  last column, inclusive, of that run
- palm_width  output  8  end_of_palm_c - start_of_palm_c
- palm_height  output  8  count of consecutive palm rows, saturating at 255
- palm_found  output  1  palm detected in last completed frame
- params_valid  output  1  one-cycle pulse when outputs are updated

## Operation
- Row counter r and column counter c advance on each accepted pixel. c wraps at IMG_WIDTH-1 and increments r. r wraps at IMG_HEIGHT-1, which ends the frame. The next accepted pixel is (0,0).
- Per row:
  - Track the current run start and length.
  - Keep the longest run's start and end. A later run replaces the kept run only if it is strictly longer, so the earliest run wins a tie.
  - A run still open at c = IMG_WIDTH-1 ends at that column.
  - Row evaluation happens on the row's last pixel and includes that pixel.
- FSM, states SEARCH → MEASURE → DONE:
  - SEARCH: if the row's longest run ≥ MIN_PALM_RUN, latch r, run start and run end into working registers, set height = 1, go to MEASURE. Otherwise stay.
  - MEASURE: if the row's longest run ≥ MIN_PALM_RUN, height++ (saturating). Otherwise go to DONE. Run position is not re-latched.
  - DONE: ignore the rest of the frame.
- End of frame, in any state:
  - Copy the working registers to the output registers.
  - palm_found = 1 if the FSM left SEARCH during the frame.
  - If no palm was found, all geometry outputs are 0.
  - Working state returns to SEARCH and is cleared.
- Outputs are double-buffered. They stay stable for the whole next frame until the next end-of-frame update.
- A frame that ends in MEASURE reports the height counted so far.

## Timing
- object_image is sampled at posedge when pixel_valid = 1. When pixel_valid = 0, no counter or state changes. Gaps of any length are allowed, including mid-row.
- Output registers update, and params_valid is high, in the cycle after the edge that accepts the frame's last pixel (r = IMG_HEIGHT-1, c = IMG_WIDTH-1). params_valid lasts exactly one cycle, independent of pixel_valid in that cycle.
- Back-to-back frames with pixel_valid held high are supported. The first pixel of frame N+1 may be accepted on the same edge that raises params_valid for frame N.
- Reset (asynchronous, at any time):
  - All outputs go to 0, including params_valid and palm_found.
  - Counters are 0 and the FSM is in SEARCH.
  - A partial frame is discarded with no params_valid. The first pixel accepted after reset release is (0,0).
- Latency from last pixel to result: 1 cycle. Throughput: 1 pixel per clock.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately, params_valid stays 0 until the first full frame completes.
- Rectangle frame (defaults), object pixels at rows 10..48, cols 78..110, pixel_valid always high → single params_valid pulse 1 cycle after pixel (95,127). Result: start (10,78), end (10,110), width 32, height 39, palm_found 1.
- Empty frame → params_valid pulse, palm_found 0, all geometry 0. Outputs from the previous frame are replaced.
- Threshold and tie cases:
  - Row 5 with a single run at cols 0..14 (length 15) → rejected.
  - Row 6 with runs at 20..35 and 50..65 (both 16), rows 7..8 empty → start (6,20), end_c 35, width 15, height 1.
- Edge run and gaps: row 0 with cols 100..127 set, rows 1..2 also set, pixel_valid toggling 1/0 every cycle → start (0,100), end_c 127, width 27, height 3. params_valid comes 1 cycle after the last accepted pixel.
- Reset mid-frame at row 30 of the rectangle frame, then a full rectangle frame → exactly one params_valid pulse, with the same result as the rectangle frame scenario.
